// File: rtl/alu_result_checker.sv
// In-order scoreboard for ALU result records against a preloaded expected table.
// Define CHECKER_OPERANDS_EN to carry operands A/B through the FIFO for first-mismatch capture.
module alu_result_checker #(
  parameter  int unsigned DEPTH   = 16,
  parameter  int unsigned ENTRIES = 64,
  localparam int unsigned AW      = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          res_valid,
  output logic          res_ready,
  input  logic [3:0]    res_ctrl,
  input  logic [31:0]   res_a,
  input  logic [31:0]   res_b,
  input  logic [31:0]   res_value,
  input  logic          exp_we,
  input  logic [AW-1:0] exp_addr,
  input  logic [35:0]   exp_data,
  input  logic [AW:0]   num_expected,
  input  logic          start,
  input  logic          hold,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   mismatch_count,
  output logic [AW-1:0] first_mis_idx,
  output logic [31:0]   first_mis_value,
  output logic [31:0]   first_mis_exp,
  output logic [31:0]   first_mis_a,
  output logic [31:0]   first_mis_b
);

`ifdef CHECKER_OPERANDS_EN
  localparam int unsigned RW = 100;
`else
  localparam int unsigned RW = 36;
`endif
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;

  logic [RW-1:0] fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   fifo_cnt;
  logic          fifo_full;
  logic          fifo_empty;

  logic [35:0]   exp_mem [ENTRIES];

  logic [AW:0]   num_exp_r;
  logic [AW:0]   pushed;
  logic [AW:0]   compared;
  logic [AW-1:0] pop_idx;

  logic          push;
  logic          pop;
  logic [RW-1:0] push_rec;

  logic          s1_valid;
  logic [RW-1:0] s1_rec;
  logic [35:0]   s1_exp;
  logic [AW-1:0] s1_idx;
  logic          s1_mis;
  logic          first_seen;

`ifdef CHECKER_OPERANDS_EN
  assign push_rec = {res_ctrl, res_a, res_b, res_value};
`else
  assign push_rec = {res_ctrl, res_value};
  logic unused_operands;
  assign unused_operands = ^{res_a, res_b};
`endif

  assign fifo_full  = (fifo_cnt == (PW+1)'(DEPTH));
  assign fifo_empty = (fifo_cnt == '0);

  // Ready depends only on registered state so a full FIFO blocks the push even if a pop happens.
  assign res_ready = (state == RUN) && !fifo_full && (pushed < num_exp_r);
  assign push      = res_valid && res_ready;
  assign pop       = (state == RUN) && !fifo_empty && !hold;

  assign s1_mis = (s1_rec[RW-1 -: 4] != s1_exp[35:32]) ||
                  (s1_rec[31:0]      != s1_exp[31:0]);

  // Storage arrays carry no reset; the expected table must survive reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_rec;
    if (pop)  s1_rec <= fifo_mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (exp_we && (state != RUN)) exp_mem[exp_addr] <= exp_data;
    if (pop) s1_exp <= exp_mem[pop_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_cnt        <= '0;
      num_exp_r       <= '0;
      pushed          <= '0;
      compared        <= '0;
      pop_idx         <= '0;
      s1_valid        <= 1'b0;
      s1_idx          <= '0;
      first_seen      <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      mismatch_count  <= '0;
      first_mis_idx   <= '0;
      first_mis_value <= '0;
      first_mis_exp   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        pushed <= pushed + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        pop_idx <= pop_idx + AW'(1);
        s1_idx  <= pop_idx;
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
        default: ;
      endcase

      s1_valid <= pop;
      if (s1_valid) begin
        compared <= compared + (AW+1)'(1);
        if (s1_mis) begin
          if (mismatch_count != '1) mismatch_count <= mismatch_count + 16'd1;
          if (!first_seen) begin
            first_seen      <= 1'b1;
            first_mis_idx   <= s1_idx;
            first_mis_value <= s1_rec[31:0];
            first_mis_exp   <= s1_exp[31:0];
          end
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            num_exp_r       <= num_expected;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_cnt        <= '0;
            pushed          <= '0;
            compared        <= '0;
            pop_idx         <= '0;
            s1_valid        <= 1'b0;
            first_seen      <= 1'b0;
            mismatch_count  <= '0;
            first_mis_idx   <= '0;
            first_mis_value <= '0;
            first_mis_exp   <= '0;
            if (num_expected == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (compared == num_exp_r) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (mismatch_count == '0);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CHECKER_OPERANDS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      first_mis_a <= '0;
      first_mis_b <= '0;
    end else if ((state != RUN) && start) begin
      first_mis_a <= '0;
      first_mis_b <= '0;
    end else if (s1_valid && s1_mis && !first_seen) begin
      first_mis_a <= s1_rec[95:64];
      first_mis_b <= s1_rec[63:32];
    end
  end
`else
  assign first_mis_a = '0;
  assign first_mis_b = '0;
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: vector table of check runs plus hand-written
// backpressure, zero-length and mid-run reset sequences, scored by a record queue.
module tb_alu_result_checker;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned ENTRIES = 64;
  localparam int unsigned AW      = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          res_valid = 1'b0;
  logic          res_ready;
  logic [3:0]    res_ctrl = '0;
  logic [31:0]   res_a = '0;
  logic [31:0]   res_b = '0;
  logic [31:0]   res_value = '0;
  logic          exp_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [35:0]   exp_data = '0;
  logic [AW:0]   num_expected = '0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic          busy, done, pass;
  logic [15:0]   mismatch_count;
  logic [AW-1:0] first_mis_idx;
  logic [31:0]   first_mis_value, first_mis_exp, first_mis_a, first_mis_b;

  always #5 clk = ~clk;

  alu_result_checker #(.DEPTH(DEPTH), .ENTRIES(ENTRIES)) dut (
    .clk(clk), .reset(reset),
    .res_valid(res_valid), .res_ready(res_ready), .res_ctrl(res_ctrl),
    .res_a(res_a), .res_b(res_b), .res_value(res_value),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .num_expected(num_expected), .start(start), .hold(hold),
    .busy(busy), .done(done), .pass(pass), .mismatch_count(mismatch_count),
    .first_mis_idx(first_mis_idx), .first_mis_value(first_mis_value),
    .first_mis_exp(first_mis_exp), .first_mis_a(first_mis_a), .first_mis_b(first_mis_b)
  );

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] value;
    int          idx;
  } rec_t;

  typedef struct {
    int n;
    int kind;      // 0 clean, 1 value error at m0, 2 ctrl error at m0
    int m0;
    int m1;        // second value error, -1 for none
    int exp_cnt;
    int exp_fidx;
    bit exp_pass;
  } vec_t;

  int unsigned n_vec = 0;
  int unsigned n_mis = 0;
  logic [3:0]  m_ctrl [ENTRIES];
  logic [31:0] m_val  [ENTRIES];
  rec_t        sb_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Table entries flagged m0/m1 are forced to {ctrl 0, value 6}.
  task automatic load_table(input int n, input int m0, input int m1);
    for (int i = 0; i < n; i++) begin
      m_ctrl[i] = 4'($urandom_range(0, 15));
      m_val[i]  = $urandom;
      if (i == m0 || i == m1) begin
        m_ctrl[i] = 4'h0;
        m_val[i]  = 32'h6;
      end
      exp_we   = 1'b1;
      exp_addr = AW'(i);
      exp_data = {m_ctrl[i], m_val[i]};
      tick();
    end
    exp_we = 1'b0;
  endtask

  task automatic start_run(input int n);
    num_expected = (AW+1)'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic rec_t make_rec(input int i, input int kind, input int m0, input int m1);
    rec_t r;
    r.idx   = i;
    r.ctrl  = m_ctrl[i];
    r.value = m_val[i];
    r.a     = $urandom;
    r.b     = $urandom;
    if (i == m0) begin
      if (kind == 2) r.ctrl = 4'h1;
      else if (kind == 1) r.value = 32'h5;
    end
    if (i == m1) r.value = 32'h5;
    return r;
  endfunction

  task automatic drive(input rec_t r);
    res_valid = 1'b1;
    res_ctrl  = r.ctrl;
    res_a     = r.a;
    res_b     = r.b;
    res_value = r.value;
  endtask

  task automatic push_range(input int from, input int to, input int kind, input int m0, input int m1);
    rec_t r;
    bit   hs;
    int   guard;
    for (int i = from; i < to; i++) begin
      r = make_rec(i, kind, m0, m1);
      drive(r);
      guard = 0;
      hs = 1'b0;
      while (!hs && guard < 50) begin
        hs = res_ready;
        tick();
        guard++;
      end
      if (!hs) begin
        check("push_handshake", 64'(hs), 64'd1);
        break;
      end
      sb_q.push_back(r);
    end
    res_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int g = 0;
    while (!done && g < 200) begin
      tick();
      g++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  // Pops every accepted record and derives the run's outcome from the bench table.
  task automatic score(input string tag);
    rec_t          r;
    int            cnt = 0;
    bit            seen = 1'b0;
    logic [AW-1:0] fi = '0;
    logic [31:0]   fv = '0, fe = '0, fa = '0, fb = '0;
    while (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      if (r.ctrl !== m_ctrl[r.idx] || r.value !== m_val[r.idx]) begin
        cnt++;
        if (!seen) begin
          seen = 1'b1;
          fi = AW'(r.idx);
          fv = r.value;
          fe = m_val[r.idx];
          fa = r.a;
          fb = r.b;
        end
      end
    end
`ifndef CHECKER_OPERANDS_EN
    fa = '0;
    fb = '0;
`endif
    check({tag, "_sb_cnt"},  64'(mismatch_count),  64'(cnt));
    check({tag, "_sb_pass"}, 64'(pass),            64'(cnt == 0));
    check({tag, "_sb_fidx"}, 64'(first_mis_idx),   64'(fi));
    check({tag, "_sb_fval"}, 64'(first_mis_value), 64'(fv));
    check({tag, "_sb_fexp"}, 64'(first_mis_exp),   64'(fe));
    check({tag, "_sb_fa"},   64'(first_mis_a),     64'(fa));
    check({tag, "_sb_fb"},   64'(first_mis_b),     64'(fb));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_done"},  64'(done), 64'd0);
    check({tag, "_pass"},  64'(pass), 64'd0);
    check({tag, "_ready"}, 64'(res_ready), 64'd0);
    check({tag, "_cnt"},   64'(mismatch_count), 64'd0);
    check({tag, "_fidx"},  64'(first_mis_idx), 64'd0);
    check({tag, "_fval"},  64'(first_mis_value), 64'd0);
    check({tag, "_fexp"},  64'(first_mis_exp), 64'd0);
    check({tag, "_fab"},   64'({first_mis_a, first_mis_b}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [6];
    rec_t r;
    int   acc;
    int   g;
    bit   hs;

    vecs[0] = '{4,  0, -1, -1, 0, 0,  1'b1};
    vecs[1] = '{4,  1,  2, -1, 1, 2,  1'b0};
    vecs[2] = '{4,  2,  0, -1, 1, 0,  1'b0};
    vecs[3] = '{8,  1,  3,  6, 2, 3,  1'b0};
    vecs[4] = '{1,  1,  0, -1, 1, 0,  1'b0};
    vecs[5] = '{64, 1, 63, -1, 1, 63, 1'b0};

    repeat (3) tick();
    reset = 1'b0;
    check_all_zero("reset");

    // Zero-length run from IDLE: done/pass one cycle after start, never ready.
    num_expected = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_done", 64'(done), 64'd1);
    check("zero_pass", 64'(pass), 64'd1);
    res_valid = 1'b1;
    tick();
    check("zero_ready", 64'(res_ready), 64'd0);
    res_valid = 1'b0;

    for (int v = 0; v < 6; v++) begin
      load_table(vecs[v].n, vecs[v].m0, vecs[v].m1);
      start_run(vecs[v].n);
      check($sformatf("v%0d_busy", v), 64'(busy), 64'd1);
      push_range(0, vecs[v].n, vecs[v].kind, vecs[v].m0, vecs[v].m1);
      check($sformatf("v%0d_ready_after_last", v), 64'(res_ready), 64'd0);
      tick();
      tick();
      check($sformatf("v%0d_done_early", v), 64'(done), 64'd0);
      tick();
      check($sformatf("v%0d_done_lat", v), 64'(done), 64'd1);
      check($sformatf("v%0d_cnt", v),  64'(mismatch_count), 64'(vecs[v].exp_cnt));
      check($sformatf("v%0d_fidx", v), 64'(first_mis_idx),  64'(vecs[v].exp_fidx));
      check($sformatf("v%0d_pass", v), 64'(pass),           64'(vecs[v].exp_pass));
      if (v == 1) begin
        check("v1_fval", 64'(first_mis_value), 64'h5);
        check("v1_fexp", 64'(first_mis_exp),   64'h6);
      end
      score($sformatf("v%0d", v));
    end

    // Backpressure: hold stalls compares, FIFO fills to DEPTH, writes in RUN are ignored.
    load_table(20, -1, -1);
    hold = 1'b1;
    start_run(20);
    acc = 0;
    for (int c = 0; c < 30; c++) begin
      r = make_rec(acc, 0, -1, -1);
      drive(r);
      exp_we   = (c == 5);
      exp_addr = AW'(18);
      exp_data = {4'hF, 32'hDEADBEEF};
      hs = res_ready;
      tick();
      if (hs) begin
        sb_q.push_back(r);
        acc++;
      end
    end
    exp_we = 1'b0;
    check("hold_accepted", 64'(acc), 64'd16);
    check("hold_ready", 64'(res_ready), 64'd0);
    check("hold_busy", 64'(busy), 64'd1);
    hold = 1'b0;
    g = 0;
    while (acc < 20 && g < 100) begin
      r = make_rec(acc, 0, -1, -1);
      drive(r);
      hs = res_ready;
      tick();
      g++;
      if (hs) begin
        sb_q.push_back(r);
        acc++;
      end
    end
    res_valid = 1'b0;
    check("hold_total", 64'(acc), 64'd20);
    wait_done("hold");
    check("hold_pass", 64'(pass), 64'd1);
    score("hold");

    // Reset after 3 of 8 records, then a clean rerun on the retained table.
    load_table(8, 0, -1);
    start_run(8);
    push_range(0, 3, 1, 0, -1);
    repeat (3) tick();
    check("pre_reset_cnt", 64'(mismatch_count), 64'd1);
    check("pre_reset_fval", 64'(first_mis_value), 64'h5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_q.delete();
    check_all_zero("midreset");
    start_run(8);
    push_range(0, 8, 0, -1, -1);
    wait_done("rerun");
    check("rerun_pass", 64'(pass), 64'd1);
    score("rerun");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
